// File: rtl/vx_commit_pkg.sv
// ============================================================================
//  Module      : vx_commit_pkg
//  Description : Shared types and constants for the commit arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vx_commit_pkg;

    localparam int CMT_NUM_UNITS   = 4;
    localparam int CMT_NUM_THREADS = 4;
    localparam int CMT_NW_BITS     = 2;
    localparam int CMT_NR_BITS     = 6;
    localparam int CMT_XLEN        = 32;

    localparam int UNIT_ALU = 0;
    localparam int UNIT_LSU = 1;
    localparam int UNIT_SFU = 2;
    localparam int UNIT_FPU = 3;

    localparam int PKT_W = CMT_NW_BITS + CMT_NUM_THREADS + CMT_XLEN + 1
                         + CMT_NR_BITS + CMT_NUM_THREADS * CMT_XLEN + 1;

    typedef struct packed {
        logic [CMT_NW_BITS-1:0]              wid;
        logic [CMT_NUM_THREADS-1:0]          tmask;
        logic [CMT_XLEN-1:0]                 PC;
        logic                                wb;
        logic [CMT_NR_BITS-1:0]              rd;
        logic [CMT_NUM_THREADS*CMT_XLEN-1:0] data;
        logic                                eop;
    } commit_data_t;

endpackage

`default_nettype wire

// File: rtl/vx_rr_arbiter.sv
// ============================================================================
//  Module      : vx_rr_arbiter
//  Description : Combinational round-robin grant with a rotating pointer that
//                advances past the winner only when enable is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     requests_i,
    input  logic             enable_i,
    output logic [N-1:0]     grant_onehot_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [N-1:0]     w_hi;

    always_comb begin
        // Requests at or above the pointer win first; otherwise wrap to the bottom.
        w_hi = '0;
        for (int j = 0; j < N; j++) begin
            w_hi[j] = requests_i[j] && (j >= int'(ptr_q));
        end

        grant_valid_o = |requests_i;
        grant_idx_o   = '0;
        if (|w_hi) begin
            for (int j = N - 1; j >= 0; j--) begin
                if (w_hi[j]) grant_idx_o = j[IDX_W-1:0];
            end
        end else begin
            for (int j = N - 1; j >= 0; j--) begin
                if (requests_i[j]) grant_idx_o = j[IDX_W-1:0];
            end
        end

        grant_onehot_o = '0;
        for (int j = 0; j < N; j++) begin
            grant_onehot_o[j] = grant_valid_o && (grant_idx_o == j[IDX_W-1:0]);
        end

        ptr_d = ptr_q;
        if (enable_i && grant_valid_o) begin
            ptr_d = (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vx_commit_arbiter.sv
// ============================================================================
//  Module      : vx_commit_arbiter
//  Description : Round-robin merge of execute-unit commit packets into a
//                2-entry buffer feeding the writeback port. Optional perf
//                counters are built when VX_COMMIT_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_commit_arbiter
    import vx_commit_pkg::*;
#(
    parameter  int NUM_UNITS   = CMT_NUM_UNITS,
    parameter  int NUM_THREADS = CMT_NUM_THREADS,
    parameter  int NW_BITS     = CMT_NW_BITS,
    parameter  int NR_BITS     = CMT_NR_BITS,
    parameter  int XLEN        = CMT_XLEN,
    localparam int PACKET_W    = NW_BITS + NUM_THREADS + XLEN + 1 + NR_BITS
                               + NUM_THREADS * XLEN + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_UNITS-1:0]          in_valid,
    input  logic [NUM_UNITS*PACKET_W-1:0] in_data,
    output logic [NUM_UNITS-1:0]          in_ready,
    output logic                          out_valid,
    output logic [PACKET_W-1:0]           out_data,
    input  logic                          out_ready
`ifdef VX_COMMIT_PERF_EN
    ,
    output logic [63:0]                   perf_instrs,
    output logic [63:0]                   perf_thread_ops
`endif
);

    localparam int UIDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int TMASK_LSB = 1 + NUM_THREADS * XLEN + NR_BITS + 1 + XLEN;

    logic [NUM_UNITS-1:0] w_grant_oh;
    logic [UIDX_W-1:0]    w_grant_idx;
    logic                 w_grant_valid;
    logic                 w_can_push;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tail;
    logic [PACKET_W-1:0]  w_pkt;

    logic [1:0]           count_q;
    logic [1:0]           count_d;
    logic                 head_q;
    logic                 head_d;
    logic [PACKET_W-1:0]  buf_q [2];

    // Space is judged on the registered count only, so in_ready never sees out_ready.
    assign w_can_push = !reset && (count_q != 2'd2);
    assign w_push     = w_can_push && w_grant_valid;
    assign w_pop      = (count_q != 2'd0) && out_ready;
    assign w_tail     = head_q ^ (count_q == 2'd1);

    vx_rr_arbiter #(
        .N (NUM_UNITS)
    ) u_rr_arbiter (
        .clk            (clk),
        .reset          (reset),
        .requests_i     (in_valid),
        .enable_i       (w_can_push),
        .grant_onehot_o (w_grant_oh),
        .grant_idx_o    (w_grant_idx),
        .grant_valid_o  (w_grant_valid)
    );

    always_comb begin
        w_pkt = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (w_grant_idx == u[UIDX_W-1:0]) w_pkt = in_data[u*PACKET_W +: PACKET_W];
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        head_d = w_pop ? ~head_q : head_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            head_q   <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (w_push) buf_q[w_tail] <= w_pkt;
        end
    end

    assign in_ready  = w_grant_oh & {NUM_UNITS{w_can_push}};
    assign out_valid = (count_q != 2'd0);
    assign out_data  = buf_q[head_q];

`ifdef VX_COMMIT_PERF_EN
    logic [63:0]            instrs_q;
    logic [63:0]            ops_q;
    logic [63:0]            w_lane_cnt;
    logic [NUM_THREADS-1:0] w_head_tmask;

    assign w_head_tmask = out_data[TMASK_LSB +: NUM_THREADS];

    always_comb begin
        w_lane_cnt = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_lane_cnt = w_lane_cnt + 64'(w_head_tmask[t]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instrs_q <= '0;
            ops_q    <= '0;
        end else if (w_pop) begin
            instrs_q <= instrs_q + 64'(out_data[0]);
            ops_q    <= ops_q + w_lane_cnt;
        end
    end

    assign perf_instrs     = instrs_q;
    assign perf_thread_ops = ops_q;
`else
    // Counters are not built; the tmask field is carried through untouched.
`endif

endmodule

`default_nettype wire

// File: tb/tb_vx_commit_arbiter.sv
// ============================================================================
//  Module      : tb_vx_commit_arbiter
//  Description : Self-checking bench for vx_commit_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_commit_arbiter;
    import vx_commit_pkg::*;

    localparam int NU = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NU-1:0]       in_valid;
    logic [NU*PKT_W-1:0] in_data;
    logic [NU-1:0]       in_ready;
    logic                out_valid;
    logic [PKT_W-1:0]    out_data;
    logic                out_ready;
`ifdef VX_COMMIT_PERF_EN
    logic [63:0]         perf_instrs;
    logic [63:0]         perf_thread_ops;
`endif

    commit_data_t src_pkt [NU];
    assign in_data = {src_pkt[3], src_pkt[2], src_pkt[1], src_pkt[0]};

    vx_commit_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef VX_COMMIT_PERF_EN
        ,
        .perf_instrs     (perf_instrs),
        .perf_thread_ops (perf_thread_ops)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          rst;
        logic [NU-1:0] vld;
        logic          ordy;
        logic [NU-1:0] rdy;
        logic          ov;
        int            head;   // unit whose packet must be at the head; 4 = zero packet; -1 = don't care
    } vec_t;

    vec_t         tbl [15];
    commit_data_t fx  [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic commit_data_t rand_pkt();
        commit_data_t p;
        p.wid   = 2'($urandom);
        p.tmask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
        p.PC    = $urandom;
        p.wb    = 1'($urandom);
        p.rd    = 6'($urandom);
        p.data  = {$urandom, $urandom, $urandom, $urandom};
        p.eop   = 1'($urandom);
        return p;
    endfunction

    // Reference model state: an ordered list of accepted packets and a rotating start unit.
    commit_data_t q_m [$];
    int           rr_m;
    logic [63:0]  m_instrs;
    logic [63:0]  m_ops;

    initial begin
        commit_data_t p;
        int           g;
        logic [NU-1:0] exp_rdy;

        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int u = 0; u < NU; u++) src_pkt[u] = '0;
        for (int u = 0; u < NU; u++) begin
            fx[u]       = rand_pkt();
            fx[u].rd    = 6'(u + 1);
            fx[u].PC    = 32'h1000 * (u + 1);
        end
        fx[4] = '0;
        tick();
        tick();

        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, -1};
        tbl[1]  = '{1'b0, 4'b0111, 1'b0, 4'b0001, 1'b0,  4};
        tbl[2]  = '{1'b0, 4'b0111, 1'b0, 4'b0010, 1'b1,  0};
        tbl[3]  = '{1'b0, 4'b0111, 1'b0, 4'b0000, 1'b1,  0};
        tbl[4]  = '{1'b0, 4'b0111, 1'b0, 4'b0000, 1'b1,  0};
        tbl[5]  = '{1'b0, 4'b0111, 1'b1, 4'b0000, 1'b1,  0};
        tbl[6]  = '{1'b0, 4'b0111, 1'b1, 4'b0100, 1'b1,  1};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1,  2};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1,  3};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1,  0};
        tbl[10] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1,  0};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0,  4};
        tbl[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1,  0};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1,  0};
        tbl[14] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, -1};

        for (int r = 0; r < 15; r++) begin
            reset     = tbl[r].rst;
            in_valid  = tbl[r].vld;
            out_ready = tbl[r].ordy;
            for (int u = 0; u < NU; u++) src_pkt[u] = fx[u];
            #1;
            chk($sformatf("tbl%0d in_ready", r), 256'(in_ready), 256'(tbl[r].rdy));
            chk($sformatf("tbl%0d out_valid", r), 256'(out_valid), 256'(tbl[r].ov));
            if (tbl[r].head >= 0)
                chk($sformatf("tbl%0d out_data", r), 256'(out_data), 256'(fx[tbl[r].head]));
            tick();
        end

        // Single ALU packet: one-cycle latency, identical data, then drains.
        reset = 1'b1; in_valid = '0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        p = rand_pkt();
        p.PC = 32'h8000_0000;
        p.rd = 6'd5;
        src_pkt[UNIT_ALU] = p;
        in_valid = 4'b0001;
        #1;
        chk("single in_ready", 256'(in_ready), 256'(4'b0001));
        chk("single out_valid pre", 256'(out_valid), 256'(1'b0));
        tick();
        in_valid = '0;
        #1;
        chk("single out_valid", 256'(out_valid), 256'(1'b1));
        chk("single out_data", 256'(out_data), 256'(p));
        out_ready = 1'b1;
        tick();
        chk("single drained", 256'(out_valid), 256'(1'b0));

`ifdef VX_COMMIT_PERF_EN
        reset = 1'b1; in_valid = '0; out_ready = 1'b1;
        tick();
        reset = 1'b0;
        chk("perf instrs reset", 256'(perf_instrs), 256'(64'd0));
        chk("perf ops reset", 256'(perf_thread_ops), 256'(64'd0));
        for (int k = 0; k < 3; k++) begin
            p = rand_pkt();
            p.tmask = 4'b1011;
            p.eop = (k != 1);
            src_pkt[UNIT_ALU] = p;
            in_valid = 4'b0001;
            tick();
        end
        in_valid = '0;
        tick();
        tick();
        chk("perf instrs", 256'(perf_instrs), 256'(64'd2));
        chk("perf thread_ops", 256'(perf_thread_ops), 256'(64'd9));
`endif

        // Randomized run against the queue model; sources hold until accepted.
        reset = 1'b1; in_valid = '0; out_ready = 1'b0;
        tick();
        q_m.delete();
        rr_m = 0;
        m_instrs = '0;
        m_ops = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int u = 0; u < NU; u++) begin
                if (!in_valid[u] && $urandom_range(0, 2) == 0) begin
                    in_valid[u] = 1'b1;
                    src_pkt[u] = rand_pkt();
                end
            end
            #1;
            g = -1;
            if (q_m.size() < 2) begin
                for (int k = 0; k < NU; k++) begin
                    if (g < 0 && in_valid[(rr_m + k) % NU]) g = (rr_m + k) % NU;
                end
            end
            exp_rdy = '0;
            if (!reset && g >= 0) exp_rdy[g] = 1'b1;
            chk($sformatf("rnd%0d in_ready", cyc), 256'(in_ready), 256'(exp_rdy));
            chk($sformatf("rnd%0d out_valid", cyc), 256'(out_valid), 256'(q_m.size() != 0));
            if (q_m.size() != 0)
                chk($sformatf("rnd%0d out_data", cyc), 256'(out_data), 256'(q_m[0]));
`ifdef VX_COMMIT_PERF_EN
            chk($sformatf("rnd%0d perf_instrs", cyc), 256'(perf_instrs), 256'(m_instrs));
            chk($sformatf("rnd%0d perf_ops", cyc), 256'(perf_thread_ops), 256'(m_ops));
`endif
            if (reset) begin
                q_m.delete();
                rr_m = 0;
                m_instrs = '0;
                m_ops = '0;
                g = -1;
            end else begin
                if (q_m.size() != 0 && out_ready) begin
                    p = q_m.pop_front();
                    m_instrs = m_instrs + 64'(p.eop);
                    m_ops = m_ops + 64'($countones(p.tmask));
                end
                if (g >= 0) begin
                    q_m.push_back(src_pkt[g]);
                    rr_m = (g + 1) % NU;
                end
            end
            tick();
            if (g >= 0) in_valid[g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vx_commit_arbiter.md
Name: vx_commit_arbiter

Overview:
- Per-issue-slot commit stage directly downstream of the execute block.
- Collects completed-instruction packets from the ALU, LSU, SFU and FPU/tensor unit commit outputs.
- Grants one packet per cycle with round-robin priority into a 2-entry output buffer.
- Feeds the single writeback/scoreboard-release port.
- Optionally counts retired instructions and committed thread-ops for performance CSRs.

Parameters:
- NUM_UNITS, 4, number of execute-unit commit sources (index 0=ALU, 1=LSU, 2=SFU, 3=FPU/tensor).
- NUM_THREADS, 4, threads per warp; width of tmask and of the data lane count.
- NW_BITS, 2, warp-id width.
- NR_BITS, 6, destination register index width.
- XLEN, 32, lane data and PC width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  NUM_UNITS  per-unit commit valid
- in_data  in  NUM_UNITS*PKT_W  per-unit packet {wid, tmask, PC, wb, rd, data[NUM_THREADS*XLEN], eop}; PKT_W = NW_BITS+NUM_THREADS+XLEN+1+NR_BITS+NUM_THREADS*XLEN+1
- in_ready  out  NUM_UNITS  per-unit accept
- out_valid  out  1  writeback packet valid
- out_data  out  PKT_W  writeback packet
- out_ready  in  1  writeback consumer accept
- perf_instrs  out  64  retired instructions; VX_COMMIT_PERF_EN only
- perf_thread_ops  out  64  committed thread-ops; VX_COMMIT_PERF_EN only

Behaviour:
- Reset, synchronous and active-high: buffer count=0, out_valid=0, out_data=0, rr pointer=0, in_ready=0 in the reset cycle, perf counters=0. Reset mid-operation discards buffered packets; no partial packet survives.
- Arbitration is combinational. Search starts at the rr pointer and wraps modulo NUM_UNITS; the first unit with in_valid=1 wins.
- in_ready is one-hot on the grant index when count<2. It is 0 for all units when count==2. It never depends combinationally on out_ready.
- Push occurs when the grant is valid and count<2. The granted packet is written to the buffer tail.
- After a push, rr pointer = (grant index + 1) mod NUM_UNITS. The pointer holds when there is no push.
- Pop occurs when out_valid && out_ready.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together (count==1): unchanged
  - push is impossible when count==2
- out_valid = (count!=0); out_data = buffer head. Latency from input handshake to out_valid is 1 cycle.
- With out_ready held at 1, throughput is 1 packet per cycle.
- Packets from the same unit leave in acceptance order. No packet is dropped or duplicated.
- out_data is held stable while out_valid=1 and out_ready=0.
- in_valid on a non-granted unit must be held by the source. The arbiter never asserts in_ready to a unit whose in_valid=0.
- tmask=0 packets pass through unchanged.

Optional Feature:
- Macro: VX_COMMIT_PERF_EN.
- Defined:
  - On every pop with eop=1, perf_instrs += 1.
  - On every pop, perf_thread_ops += popcount(tmask).
  - Both counters are 64-bit, wrap modulo 2^64, and reset to 0.
- Undefined: the perf ports are absent and no counter logic is generated.

Decomposition:
- Shared package vx_commit_pkg holds:
  - commit_data_t packed struct: wid, tmask, PC, wb, rd, data, eop.
  - Unit-index constants: UNIT_ALU=0, UNIT_LSU=1, UNIT_SFU=2, UNIT_FPU=3.
  - Localparam PKT_W.
- One sub-module: vx_rr_arbiter. Parameter N; inputs requests, enable; outputs grant one-hot, grant index, grant valid; holds the rotating pointer and advances it only on enable.

Test Plan:
- Single source: ALU in_valid for 1 cycle, PC=0x80000000, rd=5 -> out_valid next cycle with identical packet; count returns to 0 after pop.
- All 4 units valid continuously, out_ready=1 -> grant order ALU, LSU, SFU, FPU, ALU...; one packet per cycle; no unit starves.
- Backpressure: out_ready=0 with 3 units valid -> exactly 2 accepted, then in_ready=0 for all. out_data holds the first packet. Releasing out_ready delivers in acceptance order.
- Simultaneous push/pop at count=1 -> count stays 1; the new packet appears after the head pops.
- Reset asserted with count=2 -> next cycle out_valid=0, rr pointer=0; the next grant with all units valid goes to ALU.
- VX_COMMIT_PERF_EN: 3 pops with tmask=4'b1011, eop=1,0,1 -> perf_instrs=2, perf_thread_ops=9.
